// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default widths, result-stage FSM
// states and the opcode -> retire-kind classifier.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 5;

    localparam logic [OP_W_DEF-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 5'd4;
    localparam logic [OP_W_DEF-1:0] OP_SHL  = 5'd5;
    localparam logic [OP_W_DEF-1:0] OP_SHR  = 5'd6;
    localparam logic [OP_W_DEF-1:0] OP_ROL  = 5'd7;
    localparam logic [OP_W_DEF-1:0] OP_ROR  = 5'd8;
    localparam logic [OP_W_DEF-1:0] OP_NEG  = 5'd9;
    localparam logic [OP_W_DEF-1:0] OP_NOT  = 5'd10;
    localparam logic [OP_W_DEF-1:0] OP_MUL  = 5'd11;
    localparam logic [OP_W_DEF-1:0] OP_DIV  = 5'd12;
    localparam logic [OP_W_DEF-1:0] OP_MFHI = 5'd13;
    localparam logic [OP_W_DEF-1:0] OP_MFLO = 5'd14;
    localparam logic [OP_W_DEF-1:0] OP_NOP  = 5'd15;
    localparam logic [OP_W_DEF-1:0] OP_HALT = 5'd16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HILO = 2'd1,
        DRV     = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BUS_Z  = 3'd0,
        BUS_HI = 3'd1,
        BUS_LO = 3'd2,
        HILO   = 3'd3,
        NONE   = 3'd4
    } retire_kind_t;

    // Where a result goes; anything not recognised is an ordinary 32-bit bus result.
    function automatic retire_kind_t retire_kind(input logic [OP_W_DEF-1:0] op);
        retire_kind_t k;
        case (op)
            OP_MUL, OP_DIV:   k = HILO;
            OP_MFHI:          k = BUS_HI;
            OP_MFLO:          k = BUS_LO;
            OP_NOP, OP_HALT:  k = NONE;
            default:          k = BUS_Z;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/result_skid_buf.sv
// One-entry valid/ready skid buffer of generic width. When the consumer is
// ready and the buffer is empty, input passes straight through.
module result_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full
);

    logic         full_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = ~full_reg;
    assign out_valid = full_reg | in_valid;
    assign out_data  = full_reg ? data_reg : in_data;
    assign full      = full_reg;

    // Capture input only when it cannot pass through; drain when consumer takes it.
    always_ff @(posedge clk) begin
        if (srst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (full_reg) begin
            if (out_ready) begin
                full_reg <= 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: holds the 64-bit ALU result in ZHI/ZLO and retires it to
// the datapath bus or to HI/LO, strictly in acceptance order.
// Optional feature: define RESULT_SKID_EN to add a one-entry input skid buffer
// allowing one bus result per cycle.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                c_valid,
    output logic                c_ready,
    input  logic [2*DATA_W-1:0] C_reg,
    input  logic [OP_W-1:0]     opcode,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [DATA_W-1:0]   bus_data,
    output logic [DATA_W-1:0]   HI_out,
    output logic [DATA_W-1:0]   LO_out,
    output logic                busy
);

    localparam int ENTRY_W = 2*DATA_W + OP_W;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   zhi_reg, zlo_reg;
    logic [DATA_W-1:0]   hi_reg, lo_reg;
    logic [DATA_W-1:0]   bus_data_reg, bus_data_next;
    logic [DATA_W-1:0]   hi_next, lo_next;

    logic                src_valid;
    logic [ENTRY_W-1:0]  src_entry;
    logic [2*DATA_W-1:0] src_c;
    logic [OP_W-1:0]     src_op;
    retire_kind_t        src_kind;
    logic                z_ready;
    logic                load;
    logic                skid_full;

`ifdef RESULT_SKID_EN
    logic skid_in_ready;

    // Z accepts a new entry in IDLE or on the edge the current result retires.
    assign z_ready = (state_reg == IDLE) || (state_reg == WR_HILO) ||
                     ((state_reg == DRV) && bus_ready);

    result_skid_buf #(
        .W(ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .srst      (clear),
        .in_valid  (c_valid),
        .in_ready  (skid_in_ready),
        .in_data   ({C_reg, opcode}),
        .out_valid (src_valid),
        .out_ready (z_ready),
        .out_data  (src_entry),
        .full      (skid_full)
    );

    assign c_ready = skid_in_ready & ~clear;
`else
    assign z_ready   = (state_reg == IDLE);
    assign src_valid = c_valid;
    assign src_entry = {C_reg, opcode};
    assign skid_full = 1'b0;
    assign c_ready   = z_ready & ~clear;
`endif

    assign {src_c, src_op} = src_entry;
    assign src_kind        = retire_kind(src_op);
    assign load            = src_valid & z_ready;

    // HI/LO as they will be after this edge, so an mfhi/mflo loaded straight
    // out of WR_HILO sees the freshly written pair.
    assign hi_next = (state_reg == WR_HILO) ? zhi_reg : hi_reg;
    assign lo_next = (state_reg == WR_HILO) ? zlo_reg : lo_reg;

    assign bus_valid = (state_reg == DRV);
    assign bus_data  = bus_data_reg;
    assign HI_out    = hi_reg;
    assign LO_out    = lo_reg;
    assign busy      = (state_reg != IDLE) | skid_full;

    // Next state and the bus word captured on entry to DRV.
    always_comb begin
        state_next    = state_reg;
        bus_data_next = bus_data_reg;
        case (state_reg)
            WR_HILO: state_next = IDLE;
            DRV:     if (bus_ready) state_next = IDLE;
            default: state_next = state_reg;
        endcase
        if (load) begin
            case (src_kind)
                HILO: state_next = WR_HILO;
                BUS_HI: begin
                    state_next    = DRV;
                    bus_data_next = hi_next;
                end
                BUS_LO: begin
                    state_next    = DRV;
                    bus_data_next = lo_next;
                end
                BUS_Z: begin
                    state_next    = DRV;
                    bus_data_next = src_c[DATA_W-1:0];
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, Z pair, HI/LO and bus word registers; clear wins over everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg    <= IDLE;
            zhi_reg      <= '0;
            zlo_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            bus_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            bus_data_reg <= bus_data_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            if (load) begin
                zhi_reg <= src_c[2*DATA_W-1:DATA_W];
                zlo_reg <= src_c[DATA_W-1:0];
            end
        end
    end

endmodule
